// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and helpers for the dispatch/rename sequencer and the ROB.
package dispatch_ctrl_pkg;

  // Speculation state: non-speculative, one unresolved branch, squash cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPEC    = 2'd1,
    RECOVER = 2'd2
  } DISPATCH_STATE;

  // Next ROB tag in program order; tags run 1..rob_size, 0 is reserved.
  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned rob_size);
    return (tag >= rob_size) ? 32'd1 : tag + 32'd1;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_alloc.sv
// ROB tag allocator: tail pointer, branch checkpoint, speculative allocation
// count and occupancy, including rollback on misprediction.
module rob_tag_alloc
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE    = 8,
  parameter int unsigned ROB_TAG_LEN = $clog2(ROB_SIZE + 1)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   accept_i,
  input  logic                   branch_idle_i,
  input  logic                   spec_accept_i,
  input  logic                   mispredict_i,
  input  logic                   commit_valid_i,
  output logic [ROB_TAG_LEN-1:0] tail_o,
  output logic [ROB_TAG_LEN:0]   rob_count_o
);

  localparam int unsigned CW = ROB_TAG_LEN + 1;

  logic [ROB_TAG_LEN-1:0] tail_q, tail_d;
  logic [ROB_TAG_LEN-1:0] br_tag_q, br_tag_d;
  logic [CW-1:0]          spec_alloc_q, spec_alloc_d;
  logic [CW-1:0]          rob_count_q, rob_count_d;
  logic                   commit_eff;

  // Next-state arithmetic; a mispredict overrides any same-cycle accept,
  // which is squashed along with everything allocated after the branch.
  always_comb begin
    commit_eff   = commit_valid_i & (rob_count_q != '0);
    tail_d       = tail_q;
    br_tag_d     = br_tag_q;
    spec_alloc_d = spec_alloc_q;
    rob_count_d  = rob_count_q + CW'(accept_i) - CW'(commit_eff);
    if (mispredict_i) begin
      tail_d       = ROB_TAG_LEN'(tag_inc(32'(br_tag_q), ROB_SIZE));
      rob_count_d  = rob_count_q - spec_alloc_q - CW'(commit_eff);
      spec_alloc_d = '0;
    end else begin
      if (accept_i) begin
        tail_d = ROB_TAG_LEN'(tag_inc(32'(tail_q), ROB_SIZE));
      end
      if (branch_idle_i) begin
        br_tag_d     = tail_q;
        spec_alloc_d = '0;
      end else if (spec_accept_i) begin
        spec_alloc_d = spec_alloc_q + CW'(1);
      end
    end
  end

  // Allocator state registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tail_q       <= ROB_TAG_LEN'(1);
      br_tag_q     <= '0;
      spec_alloc_q <= '0;
      rob_count_q  <= '0;
    end else begin
      tail_q       <= tail_d;
      br_tag_q     <= br_tag_d;
      spec_alloc_q <= spec_alloc_d;
      rob_count_q  <= rob_count_d;
    end
  end

  assign tail_o      = tail_q;
  assign rob_count_o = rob_count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch/rename sequencer: in-order ROB tag allocation, map-table rename
// write, single-branch speculation FSM and one-cycle squash on mispredict.
// Optional debug counters enabled by defining DISPATCH_CTRL_STATS_EN.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE    = 8,
  parameter int unsigned ROB_TAG_LEN = $clog2(ROB_SIZE + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dispatch_valid,
  input  logic [4:0]             dispatch_rd,
  input  logic                   dispatch_is_branch,
  output logic                   dispatch_ready,
  output logic                   mt_enable,
  output logic [4:0]             mt_rd,
  output logic [ROB_TAG_LEN-1:0] mt_rob_entry,
  input  logic                   commit_valid,
  input  logic                   resolve_valid,
  input  logic                   resolve_mispredict,
  output logic                   branch_speculating,
  output logic                   branch_determined,
  output logic                   branch_misprediction,
  output logic                   squash,
  output logic [ROB_TAG_LEN:0]   rob_count,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            mispredict_count
);

  localparam logic [ROB_TAG_LEN:0] ROB_SIZE_C = (ROB_TAG_LEN + 1)'(ROB_SIZE);

  DISPATCH_STATE          state_q, state_d;
  logic                   accept;
  logic [ROB_TAG_LEN-1:0] tail;

  rob_tag_alloc #(
    .ROB_SIZE    (ROB_SIZE),
    .ROB_TAG_LEN (ROB_TAG_LEN)
  ) u_alloc (
    .clock_i        (clock),
    .reset_i        (reset),
    .accept_i       (accept),
    .branch_idle_i  (accept & dispatch_is_branch & (state_q == IDLE)),
    .spec_accept_i  (accept & (state_q == SPEC)),
    .mispredict_i   (branch_misprediction),
    .commit_valid_i (commit_valid),
    .tail_o         (tail),
    .rob_count_o    (rob_count)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && dispatch_is_branch) state_d = SPEC;
      SPEC:    if (resolve_valid) state_d = resolve_mispredict ? RECOVER : IDLE;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake, rename write and branch signals.
  always_comb begin
    dispatch_ready       = !reset && (rob_count < ROB_SIZE_C) &&
                           ((state_q == IDLE) || ((state_q == SPEC) && !dispatch_is_branch));
    accept               = dispatch_valid & dispatch_ready;
    mt_enable            = accept;
    mt_rd                = accept ? dispatch_rd : '0;
    mt_rob_entry         = accept ? tail : '0;
    branch_speculating   = (state_q == SPEC);
    squash               = (state_q == RECOVER);
    branch_determined    = resolve_valid & (state_q == SPEC);
    branch_misprediction = branch_determined & resolve_mispredict;
  end

`ifdef DISPATCH_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d, mispred_q, mispred_d;

  // Saturating debug counters.
  always_comb begin
    stall_d   = stall_q;
    mispred_d = mispred_q;
    if (dispatch_valid && !dispatch_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (branch_misprediction && (mispred_q != '1))            mispred_d = mispred_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q   <= '0;
      mispred_q <= '0;
    end else begin
      stall_q   <= stall_d;
      mispred_q <= mispred_d;
    end
  end

  assign stall_cycles     = stall_q;
  assign mispredict_count = mispred_q;
`else
  assign stall_cycles     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl (ROB_SIZE = 8).
module tb_dispatch_ctrl;

  localparam int unsigned TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          dispatch_valid, dispatch_is_branch;
  logic [4:0]    dispatch_rd;
  logic          dispatch_ready, mt_enable;
  logic [4:0]    mt_rd;
  logic [TW-1:0] mt_rob_entry;
  logic          commit_valid, resolve_valid, resolve_mispredict;
  logic          branch_speculating, branch_determined, branch_misprediction, squash;
  logic [TW:0]   rob_count;
  logic [31:0]   stall_cycles, mispredict_count;

  typedef struct packed {
    logic [4:0]    rd;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  dispatch_ctrl #(.ROB_SIZE(8), .ROB_TAG_LEN(TW)) dut (
    .clock                (clock),
    .reset                (reset),
    .dispatch_valid       (dispatch_valid),
    .dispatch_rd          (dispatch_rd),
    .dispatch_is_branch   (dispatch_is_branch),
    .dispatch_ready       (dispatch_ready),
    .mt_enable            (mt_enable),
    .mt_rd                (mt_rd),
    .mt_rob_entry         (mt_rob_entry),
    .commit_valid         (commit_valid),
    .resolve_valid        (resolve_valid),
    .resolve_mispredict   (resolve_mispredict),
    .branch_speculating   (branch_speculating),
    .branch_determined    (branch_determined),
    .branch_misprediction (branch_misprediction),
    .squash               (squash),
    .rob_count            (rob_count),
    .stall_cycles         (stall_cycles),
    .mispredict_count     (mispredict_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every rename write must match the next expected issue.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b0 && mt_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("issue_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("mt_rd", 32'(mt_rd), 32'(e.rd));
        chk("mt_rob_entry", 32'(mt_rob_entry), 32'(e.tag));
      end
    end
  end

  // One cycle of stimulus; tag != 0 means this instruction must issue with that tag.
  task automatic cyc(input logic v, input logic [4:0] rd, input logic br, input logic cm,
                     input logic rv, input logic rm, input int unsigned tag);
    exp_t e;
    @(posedge clock);
    #1;
    dispatch_valid     = v;
    dispatch_rd        = rd;
    dispatch_is_branch = br;
    commit_valid       = cm;
    resolve_valid      = rv;
    resolve_mispredict = rm;
    if (tag != 0) begin
      e.rd  = rd;
      e.tag = TW'(tag);
      exp_q.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    dispatch_valid     = 1'b0;
    dispatch_rd        = '0;
    dispatch_is_branch = 1'b0;
    commit_valid       = 1'b0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    dispatch_valid = 1'b1;
    dispatch_rd    = 5'd3;
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(dispatch_ready), 0);
    chk("rst_mt_enable", 32'(mt_enable), 0);
    chk("rst_rob_count", 32'(rob_count), 0);
    chk("rst_squash", 32'(squash), 0);
    chk("rst_speculating", 32'(branch_speculating), 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    clear_inputs();
    reset = 1'b0;

    // Fill the ROB: tags 1..8, then full, then wrap to tag 1 after a commit.
    for (int unsigned i = 1; i <= 8; i++) begin
      cyc(1'b1, 5'(i), 1'b0, 1'b0, 1'b0, 1'b0, i);
      chk("fill_ready", 32'(dispatch_ready), 1);
      chk("fill_count", 32'(rob_count), i - 1);
    end
    cyc(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("full_ready", 32'(dispatch_ready), 0);
    chk("full_count", 32'(rob_count), 8);
    cyc(1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("full_commit_ready", 32'(dispatch_ready), 0);
    cyc(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk("wrap_ready", 32'(dispatch_ready), 1);
    chk("wrap_count", 32'(rob_count), 7);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("wrap_count_after", 32'(rob_count), 8);

    // Branch at tag 3, ALU 4/5, second branch stalls, correct resolve.
    do_reset();
    cyc(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    cyc(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    cyc(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    chk("br_ready", 32'(dispatch_ready), 1);
    chk("br_spec_before", 32'(branch_speculating), 0);
    cyc(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    chk("br_spec_after", 32'(branch_speculating), 1);
    chk("br_count", 32'(rob_count), 3);
    cyc(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    cyc(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("br2_stall_ready", 32'(dispatch_ready), 0);
    chk("br2_stall_count", 32'(rob_count), 5);
    cyc(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("res_ok_ready", 32'(dispatch_ready), 0);
    chk("res_ok_determined", 32'(branch_determined), 1);
    chk("res_ok_mispred", 32'(branch_misprediction), 0);
    cyc(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    chk("br2_accept_ready", 32'(dispatch_ready), 1);
    chk("br2_accept_spec", 32'(branch_speculating), 0);
    chk("br2_accept_count", 32'(rob_count), 5);
    // Mispredict of branch 6 with a same-cycle ALU accept and commit.
    cyc(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    chk("spec2_count", 32'(rob_count), 6);
    cyc(1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 8);
    chk("mp2_determined", 32'(branch_determined), 1);
    chk("mp2_mispred", 32'(branch_misprediction), 1);
    chk("mp2_count", 32'(rob_count), 7);
    cyc(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rec2_squash", 32'(squash), 1);
    chk("rec2_ready", 32'(dispatch_ready), 0);
    chk("rec2_count", 32'(rob_count), 5);
    cyc(1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 7);
    chk("post2_squash", 32'(squash), 0);
    chk("acc_cm_count_before", 32'(rob_count), 5);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("acc_cm_count_after", 32'(rob_count), 5);
    chk("idle_res_determined", 32'(branch_determined), 0);
    chk("idle_res_mispred", 32'(branch_misprediction), 0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("idle_res_squash", 32'(squash), 0);
    chk("idle_res_spec", 32'(branch_speculating), 0);

    // Branch at tag 3, ALU 4/5, mispredict; stats window starts here.
    do_reset();
    cyc(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    cyc(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    cyc(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    cyc(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    cyc(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    chk("mp_count_pre", 32'(rob_count), 4);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("mp_determined", 32'(branch_determined), 1);
    chk("mp_mispred", 32'(branch_misprediction), 1);
    chk("mp_count", 32'(rob_count), 5);
    cyc(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rec_squash", 32'(squash), 1);
    chk("rec_ready", 32'(dispatch_ready), 0);
    chk("rec_count", 32'(rob_count), 3);
    chk("rec_spec", 32'(branch_speculating), 0);
    cyc(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    chk("resume_squash", 32'(squash), 0);
    chk("resume_ready", 32'(dispatch_ready), 1);
    chk("resume_count", 32'(rob_count), 3);
    cyc(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    chk("br5_count", 32'(rob_count), 4);
    cyc(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("br5_stall_ready", 32'(dispatch_ready), 0);
    chk("br5_spec", 32'(branch_speculating), 1);
    cyc(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("br5_stall_ready2", 32'(dispatch_ready), 0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef DISPATCH_CTRL_STATS_EN
    chk("stall_cycles", stall_cycles, 3);
    chk("mispredict_count", mispredict_count, 1);
`else
    chk("stall_cycles_off", stall_cycles, 0);
    chk("mispredict_count_off", mispredict_count, 0);
`endif

    // Asynchronous reset while in SPEC.
    reset = 1'b1;
    dispatch_valid = 1'b1;
    #1;
    chk("midrst_spec", 32'(branch_speculating), 0);
    chk("midrst_squash", 32'(squash), 0);
    chk("midrst_count", 32'(rob_count), 0);
    chk("midrst_ready", 32'(dispatch_ready), 0);
    chk("midrst_mispredict_count", mispredict_count, 0);
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("commit0_squash", 32'(squash), 0);
    cyc(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk("commit0_count", 32'(rob_count), 0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("final_count", 32'(rob_count), 1);
    #1;
    chk("pending_issues", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
